// File: rtl/score_bcd_converter.sv
// Sequential 10-bit binary to 3-digit BCD converter (double dabble, one bit per clock, 11-cycle start-to-done).
// Optional SCORE_BCD_SATURATE_EN clamps values above 999 to 9/9/9; otherwise the digits show value mod 1000.
module score_bcd_converter #(
  parameter int IN_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones,
  output logic            overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [12:0]     scr_q, scr_d;
  logic [3:0]      hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic            ovf_q, ovf_d;

  logic [12:0]     adj;
  logic [12:0]     shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    // Add-3 is per nibble and 4 bits wide; only the shift carries bits across digits.
    adj = scr_q;
    if (scr_q[3:0]  >= 4'd5) adj[3:0]  = scr_q[3:0]  + 4'd3;
    if (scr_q[7:4]  >= 4'd5) adj[7:4]  = scr_q[7:4]  + 4'd3;
    if (scr_q[11:8] >= 4'd5) adj[11:8] = scr_q[11:8] + 4'd3;
    shifted = {adj[11:0], bin_q[IN_W-1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bin_d   = value;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scr_d = shifted;
        bin_d = {bin_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(IN_W - 1)) begin
          state_d = DONE;
          ovf_d   = shifted[12];
`ifdef SCORE_BCD_SATURATE_EN
          if (shifted[12]) begin
            hund_d = 4'd9;
            tens_d = 4'd9;
            ones_d = 4'd9;
          end else begin
            hund_d = shifted[11:8];
            tens_d = shifted[7:4];
            ones_d = shifted[3:0];
          end
`else
          hund_d = shifted[11:8];
          tens_d = shifted[7:4];
          ones_d = shifted[3:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign hundreds = hund_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: latency, back-to-back, overflow, ignored start, mid-run reset, 0..999 sweep.
module tb_score_bcd_converter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] value = '0;
  logic       busy, done, overflow;
  logic [3:0] hundreds, tens, ones;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef SCORE_BCD_SATURATE_EN
  localparam logic [11:0] OVF_DIGITS = 12'h999;
`else
  localparam logic [11:0] OVF_DIGITS = 12'h023;
`endif

  score_bcd_converter dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .hundreds(hundreds), .tens(tens),
    .ones(ones), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert start for one cycle; returns in cycle T+1.
  task automatic start_conv(input logic [9:0] v);
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; n is the cycle index relative to T (11 expected), 20 on timeout.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_chk++;
    if ({busy, done, hundreds, tens, ones, overflow} !== 15'd0)
      $display("FAIL reset_state: got busy=%0b done=%0b digits=%h%h%h ovf=%0b, want all 0",
               busy, done, hundreds, tens, ones, overflow);
    else n_pass++;
  endtask

  task automatic test_zero();
    int n;
    int busy_cnt;
    start_conv(10'd0);
    n = 1;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    n_chk++;
    if (n !== 11) $display("FAIL zero_latency: got %0d, want 11", n); else n_pass++;
    n_chk++;
    if (busy_cnt !== 10) $display("FAIL zero_busy_cycles: got %0d, want 10", busy_cnt); else n_pass++;
    n_chk++;
    if ({hundreds, tens, ones, overflow, busy} !== 14'd0)
      $display("FAIL zero_result: got %h%h%h ovf=%0b busy=%0b, want 000 ovf=0 busy=0",
               hundreds, tens, ones, overflow, busy);
    else n_pass++;
    tick();
    n_chk++;
    if (done !== 1'b0) $display("FAIL zero_done_pulse: done=%0b one cycle later, want 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    int held_bad;
    start_conv(10'd255);
    wait_done(n);
    n_chk++;
    if (n !== 11) $display("FAIL b2b_first_latency: got %0d, want 11", n); else n_pass++;
    n_chk++;
    if ({hundreds, tens, ones, overflow} !== {12'h255, 1'b0})
      $display("FAIL b2b_first_result: got %h%h%h ovf=%0b, want 255 ovf=0", hundreds, tens, ones, overflow);
    else n_pass++;
    start_conv(10'd999);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL b2b_accept_in_done: busy=%0b, want 1", busy); else n_pass++;
    n = 1;
    held_bad = 0;
    while (!done && n < 20) begin
      if ({hundreds, tens, ones} !== 12'h255) held_bad++;
      tick();
      n++;
    end
    n_chk++;
    if (held_bad !== 0) $display("FAIL b2b_digits_held: %0d cycles changed, want 0", held_bad); else n_pass++;
    n_chk++;
    if (n !== 11) $display("FAIL b2b_second_latency: got %0d, want 11", n); else n_pass++;
    n_chk++;
    if ({hundreds, tens, ones, overflow} !== {12'h999, 1'b0})
      $display("FAIL b2b_second_result: got %h%h%h ovf=%0b, want 999 ovf=0", hundreds, tens, ones, overflow);
    else n_pass++;
    tick();
  endtask

  task automatic test_overflow();
    int n;
    start_conv(10'd1023);
    wait_done(n);
    n_chk++;
    if ({hundreds, tens, ones, overflow} !== {OVF_DIGITS, 1'b1})
      $display("FAIL overflow_1023: got %h%h%h ovf=%0b, want %h ovf=1",
               hundreds, tens, ones, overflow, OVF_DIGITS);
    else n_pass++;
    tick();
  endtask

  task automatic test_ignore_start();
    int dones;
    int held_bad;
    int done_at;
    dones = 0;
    held_bad = 0;
    done_at = 0;
    start_conv(10'd500);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start = (cyc == 4);
      value = (cyc == 4) ? 10'd7 : 10'd500;
      if (done) begin
        dones++;
        done_at = cyc;
        n_chk++;
        if ({hundreds, tens, ones} !== 12'h500)
          $display("FAIL ignore_result: got %h%h%h, want 500", hundreds, tens, ones);
        else n_pass++;
      end
      if (cyc <= 10 && {hundreds, tens, ones} !== OVF_DIGITS) held_bad++;
      tick();
    end
    start = 1'b0;
    n_chk++;
    if (dones !== 1 || done_at !== 11)
      $display("FAIL ignore_single_done: got %0d dones, last at %0d, want 1 at 11", dones, done_at);
    else n_pass++;
    n_chk++;
    if (held_bad !== 0) $display("FAIL ignore_digits_held: %0d cycles changed, want 0", held_bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    start_conv(10'd888);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if ({busy, done, hundreds, tens, ones, overflow} !== 15'd0)
      $display("FAIL midreset_state: busy=%0b done=%0b digits=%h%h%h ovf=%0b, want all 0",
               busy, done, hundreds, tens, ones, overflow);
    else n_pass++;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dones++;
      tick();
    end
    n_chk++;
    if (dones !== 0) $display("FAIL midreset_no_done: %0d active cycles, want 0", dones); else n_pass++;
    start_conv(10'd42);
    wait_done(n);
    n_chk++;
    if (n !== 11 || {hundreds, tens, ones, overflow} !== {12'h042, 1'b0})
      $display("FAIL midreset_restart: latency %0d digits %h%h%h ovf=%0b, want 11 042 ovf=0",
               n, hundreds, tens, ones, overflow);
    else n_pass++;
    tick();
  endtask

  task automatic test_sweep();
    int n;
    logic [12:0] exp;
    for (int v = 0; v < 1000; v++) begin
      // Gap 0 starts the next conversion in the DONE cycle.
      repeat ($urandom_range(0, 3)) tick();
      start_conv(10'(v));
      wait_done(n);
      exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), 1'b0};
      n_chk++;
      if (n !== 11 || {hundreds, tens, ones, overflow} !== exp)
        $display("FAIL sweep_%0d: latency %0d digits %h%h%h ovf=%0b, want 11 %h ovf=0",
                 v, n, hundreds, tens, ones, overflow, exp[12:1]);
      else n_pass++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_zero();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
